// File: rtl/lc3_irq_pkg.sv
// ---------------------------------------------------------------------------
// lc3_irq_pkg
// Shared types and constants for the LC-3 interrupt arbiter.
//   PRI_W / VEC_W       : widths of the core's INTP and INTV inputs
//   ST_* / state_t      : arbiter FSM encoding (IDLE, LOCK, GAP)
//   CFG_*               : bit positions inside the 16-bit configuration word
//   ch_cfg_t            : decoded per-channel configuration {en, lvl, pri}
//   decode_cfg()        : unpacks a configuration word into ch_cfg_t
// ---------------------------------------------------------------------------
package lc3_irq_pkg;

    localparam int PRI_W = 3;
    localparam int VEC_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOCK = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOCK = ST_LOCK,
        GAP  = ST_GAP
    } state_t;

    localparam int CFG_EN_BIT  = 15;
    localparam int CFG_LVL_BIT = 14;
    localparam int CFG_PRI_LSB = 0;

    typedef struct packed {
        logic             en;
        logic             lvl;
        logic [PRI_W-1:0] pri;
    } ch_cfg_t;

    function automatic ch_cfg_t decode_cfg(input logic [15:0] word);
        ch_cfg_t c;
        c.en  = word[CFG_EN_BIT];
        c.lvl = word[CFG_LVL_BIT];
        c.pri = word[CFG_PRI_LSB +: PRI_W];
        return c;
    endfunction

endpackage

// File: rtl/lc3_irq_prio_enc.sv
// ---------------------------------------------------------------------------
// lc3_irq_prio_enc
// Combinational max-priority finder over N {valid, pri} pairs.
//   valid  in  N        : channel participates in the search
//   pri    in  N x 3    : channel priority
//   found  out 1        : at least one valid channel
//   idx    out IW       : index of the winner (lowest index on a tie)
//   pri_o  out 3        : priority of the winner
// ---------------------------------------------------------------------------
module lc3_irq_prio_enc
    import lc3_irq_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]            valid,
    input  logic [N-1:0][PRI_W-1:0] pri,
    output logic                    found,
    output logic [IW-1:0]           idx,
    output logic [PRI_W-1:0]        pri_o
);

    // Scanning upward and replacing only on a strictly greater priority
    // keeps the lowest index among equal-priority candidates.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pri_o = '0;
        for (int i = 0; i < N; i++) begin
            if (valid[i] && (!found || (pri[i] > pri_o))) begin
                found = 1'b1;
                idx   = IW'(i);
                pri_o = pri[i];
            end
        end
    end

endmodule

// File: rtl/lc3_irq_arbiter.sv
// ---------------------------------------------------------------------------
// lc3_irq_arbiter
// Multi-channel interrupt arbiter driving the LC-3 core's IRQ/INTV/INTP.
// Peripheral request edges are latched as pending; the highest-priority
// enabled pending channel above the CPU priority is granted and held stable
// until the core acknowledges, followed by one idle GAP cycle.
//
// Ports:
//   clk        in   1       system clock
//   rst        in   1       asynchronous active-high reset
//   irq_req    in   NUM_CH  raw request lines (synchronous to clk)
//   cur_pri    in   3       current CPU priority (PSR[10:8])
//   int_ack    in   1       core has taken the interrupt (one-cycle pulse)
//   cfg_we     in   1       configuration write strobe
//   cfg_addr   in   CH_AW   channel selected for the write
//   cfg_wdata  in   16      [15]=enable [14]=level [2:0]=priority
//   IRQ        out  1       interrupt request to the core
//   INTV       out  8       vector of the granted channel (VEC_BASE+idx)
//   INTP       out  3       priority of the granted channel
//
// Build option: define LC3_IRQ_LEVEL_EN to enable per-channel level mode
// (cfg_wdata[14]). Without it every channel is edge-triggered.
// ---------------------------------------------------------------------------
module lc3_irq_arbiter
    import lc3_irq_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int VEC_BASE = 8'h80,
    parameter int CH_AW    = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] irq_req,
    input  logic [PRI_W-1:0]  cur_pri,
    input  logic              int_ack,
    input  logic              cfg_we,
    input  logic [CH_AW-1:0]  cfg_addr,
    input  logic [15:0]       cfg_wdata,
    output logic              IRQ,
    output logic [VEC_W-1:0]  INTV,
    output logic [PRI_W-1:0]  INTP
);

    if (NUM_CH < 2 || NUM_CH > 32 || VEC_BASE + NUM_CH > 256) begin : g_bad_param
        $error("lc3_irq_arbiter: NUM_CH must be 2..32 and VEC_BASE+NUM_CH <= 256");
    end

    ch_cfg_t wr_cfg;
    assign wr_cfg = decode_cfg(cfg_wdata);

    logic unused_cfg_bits;
`ifdef LC3_IRQ_LEVEL_EN
    assign unused_cfg_bits = ^cfg_wdata[13:3];
`else
    assign unused_cfg_bits = ^{cfg_wdata[13:3], wr_cfg.lvl};
`endif

    state_t             state_reg;
    logic               irq_reg;
    logic [VEC_W-1:0]   intv_reg;
    logic [PRI_W-1:0]   intp_reg;
    logic [CH_AW-1:0]   lock_idx_reg;
    logic [NUM_CH-1:0]  irq_req_d_reg;

    logic [NUM_CH-1:0]            rise;
    logic [NUM_CH-1:0]            en_vec;
    logic [NUM_CH-1:0]            pend_vec;
    logic [NUM_CH-1:0]            elig;
    logic [NUM_CH-1:0][PRI_W-1:0] pri_vec;
    logic                         ack_clr;

    assign rise    = irq_req & ~irq_req_d_reg;
    assign ack_clr = (state_reg == LOCK) && int_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_req_d_reg <= '0;
        else     irq_req_d_reg <= irq_req;
    end

`ifdef LC3_IRQ_LEVEL_EN
    logic [NUM_CH-1:0] lvl_vec;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic             en_reg;
            logic [PRI_W-1:0] pri_reg;
            logic             pend_reg;
            logic             cfg_hit;

            assign cfg_hit = cfg_we && (cfg_addr == CH_AW'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    en_reg  <= 1'b0;
                    pri_reg <= '0;
                end else if (cfg_hit) begin
                    en_reg  <= wr_cfg.en;
                    pri_reg <= wr_cfg.pri;
                end
            end

`ifdef LC3_IRQ_LEVEL_EN
            logic lvl_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)          lvl_reg <= 1'b0;
                else if (cfg_hit) lvl_reg <= wr_cfg.lvl;
            end
            assign lvl_vec[gi] = lvl_reg;
`endif

            // Set beats clear so an edge arriving with the ack is not lost.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    pend_reg <= 1'b0;
`ifdef LC3_IRQ_LEVEL_EN
                else if (lvl_reg)
                    pend_reg <= irq_req[gi];
`endif
                else if (rise[gi])
                    pend_reg <= 1'b1;
                else if (ack_clr && (lock_idx_reg == CH_AW'(gi)))
                    pend_reg <= 1'b0;
            end

            assign en_vec[gi]   = en_reg;
            assign pend_vec[gi] = pend_reg;
            assign pri_vec[gi]  = pri_reg;
            assign elig[gi]     = pend_reg && en_reg && (pri_reg > cur_pri);
        end
    endgenerate

    logic               win_found;
    logic [CH_AW-1:0]   win_idx;
    logic [PRI_W-1:0]   win_pri;
    logic [VEC_W-1:0]   win_vec;

    lc3_irq_prio_enc #(
        .N  (NUM_CH),
        .IW (CH_AW)
    ) u_prio_enc (
        .valid (elig),
        .pri   (pri_vec),
        .found (win_found),
        .idx   (win_idx),
        .pri_o (win_pri)
    );

    assign win_vec = VEC_W'(VEC_BASE) + VEC_W'(win_idx);

    // The disable is taken from the write itself so the grant drops on the
    // cycle right after the write rather than one cycle later.
    logic withdraw;
`ifdef LC3_IRQ_LEVEL_EN
    assign withdraw = (cfg_we && (cfg_addr == lock_idx_reg) && !wr_cfg.en)
                   || (cur_pri >= intp_reg)
                   || (lvl_vec[lock_idx_reg] && !irq_req[lock_idx_reg]);
`else
    assign withdraw = (cfg_we && (cfg_addr == lock_idx_reg) && !wr_cfg.en)
                   || (cur_pri >= intp_reg);
`endif

    logic unused_state_bits;
    assign unused_state_bits = ^{en_vec, pend_vec};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            irq_reg      <= 1'b0;
            intv_reg     <= '0;
            intp_reg     <= '0;
            lock_idx_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        irq_reg      <= 1'b1;
                        intv_reg     <= win_vec;
                        intp_reg     <= win_pri;
                        lock_idx_reg <= win_idx;
                        state_reg    <= LOCK;
                    end
                end
                LOCK: begin
                    // Ack has precedence over a simultaneous withdrawal.
                    if (int_ack) begin
                        irq_reg   <= 1'b0;
                        state_reg <= GAP;
                    end else if (withdraw) begin
                        irq_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                GAP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    irq_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign IRQ  = irq_reg;
    assign INTV = intv_reg;
    assign INTP = intp_reg;

endmodule

// File: tb/tb_lc3_irq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lc3_irq_arbiter
// Self-checking bench for lc3_irq_arbiter (NUM_CH=8, VEC_BASE=8'h80).
// Expected grants are queued when a request is stimulated and compared
// when the DUT raises IRQ.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lc3_irq_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_req;
    logic [2:0]  cur_pri;
    logic        int_ack;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        IRQ;
    logic [7:0]  INTV;
    logic [2:0]  INTP;

    lc3_irq_arbiter #(
        .NUM_CH   (8),
        .VEC_BASE (8'h80)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_req   (irq_req),
        .cur_pri   (cur_pri),
        .int_ack   (int_ack),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .IRQ       (IRQ),
        .INTV      (INTV),
        .INTP      (INTP)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] v;
        logic [2:0] p;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input logic en, input logic lvl, input logic [2:0] pri);
        cfg_we    = 1'b1;
        cfg_addr  = 3'(ch);
        cfg_wdata = {en, lvl, 11'b0, pri};
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] mask);
        irq_req = irq_req | mask;
        tick();
        irq_req = irq_req & ~mask;
    endtask

    task automatic expect_grant(input logic [7:0] v, input logic [2:0] p);
        exp_t e;
        e.v = v;
        e.p = p;
        exp_q.push_back(e);
    endtask

    // Waits up to 'budget' cycles for IRQ, then compares against the queue head.
    task automatic wait_grant(input string tag, input int budget);
        int   n;
        exp_t e;
        n = 0;
        while (IRQ !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_irq"}, 32'(IRQ), 32'd1);
        check({tag, "_sb"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_intv"}, 32'(INTV), 32'(e.v));
            check({tag, "_intp"}, 32'(INTP), 32'(e.p));
        end
    endtask

    task automatic ack(input string tag);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check({tag, "_gap"}, 32'(IRQ), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        irq_req   = '0;
        cur_pri   = '0;
        int_ack   = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        tick();
        tick();
        check("rst_irq",  32'(IRQ),  32'd0);
        check("rst_intv", 32'(INTV), 32'd0);
        check("rst_intp", 32'(INTP), 32'd0);
        rst = 1'b0;
        tick();

        // 1. priority selection, exact latency and GAP
        cfg_write(2, 1'b1, 1'b0, 3'd4);
        cfg_write(5, 1'b1, 1'b0, 3'd6);
        expect_grant(8'h85, 3'd6);
        expect_grant(8'h82, 3'd4);
        pulse(8'b0010_0100);
        check("t1_lat_edge", 32'(IRQ), 32'd0);
        tick();
        wait_grant("t1_first", 0);
        ack("t1_a");
        wait_grant("t1_second", 4);
        ack("t1_b");

        // 2. masking by cur_pri and tie-break to lowest index
        cfg_write(1, 1'b1, 1'b0, 3'd5);
        cfg_write(3, 1'b1, 1'b0, 3'd5);
        cur_pri = 3'd5;
        pulse(8'b0000_1010);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_masked", 32'(IRQ), 32'd0);
        end
        cur_pri = 3'd4;
        expect_grant(8'h81, 3'd5);
        expect_grant(8'h83, 3'd5);
        tick();
        wait_grant("t2_tie", 0);
        ack("t2_a");
        wait_grant("t2_next", 4);
        ack("t2_b");

        // 3. no preemption while locked
        cur_pri = 3'd0;
        cfg_write(0, 1'b1, 1'b0, 3'd2);
        cfg_write(7, 1'b1, 1'b0, 3'd7);
        expect_grant(8'h80, 3'd2);
        pulse(8'b0000_0001);
        wait_grant("t3_low", 4);
        expect_grant(8'h87, 3'd7);
        pulse(8'b1000_0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold_intv", 32'(INTV), 32'h80);
        end
        check("t3_hold_irq", 32'(IRQ), 32'd1);
        ack("t3_a");
        wait_grant("t3_high", 4);
        ack("t3_b");

        // 4. withdrawal by disable, pending survives
        cfg_write(4, 1'b1, 1'b0, 3'd3);
        expect_grant(8'h84, 3'd3);
        pulse(8'b0001_0000);
        wait_grant("t4_grant", 4);
        cfg_write(4, 1'b0, 1'b0, 3'd3);
        check("t4_withdraw", 32'(IRQ), 32'd0);
        tick();
        tick();
        check("t4_disabled", 32'(IRQ), 32'd0);
        expect_grant(8'h84, 3'd3);
        cfg_write(4, 1'b1, 1'b0, 3'd3);
        wait_grant("t4_regrant", 4);
        ack("t4_a");

        // 5. edge coinciding with ack is kept; pending cleared otherwise
        cfg_write(6, 1'b1, 1'b0, 3'd5);
        expect_grant(8'h86, 3'd5);
        pulse(8'b0100_0000);
        wait_grant("t5_first", 4);
        expect_grant(8'h86, 3'd5);
        irq_req[6] = 1'b1;
        int_ack    = 1'b1;
        tick();
        int_ack    = 1'b0;
        irq_req[6] = 1'b0;
        check("t5_gap", 32'(IRQ), 32'd0);
        wait_grant("t5_rereq", 4);
        ack("t5_a");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_cleared", 32'(IRQ), 32'd0);
        end

        // 5b. asynchronous reset mid-LOCK discards pending
        expect_grant(8'h86, 3'd5);
        pulse(8'b0100_0000);
        wait_grant("t5_prerst", 4);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_rst", 32'(IRQ), 32'd0);
        tick();
        rst = 1'b0;
        cfg_write(6, 1'b1, 1'b0, 3'd5);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_post_rst", 32'(IRQ), 32'd0);
        end
        expect_grant(8'h86, 3'd5);
        pulse(8'b0100_0000);
        wait_grant("t5_new_edge", 4);
        ack("t5_b");

`ifdef LC3_IRQ_LEVEL_EN
        // 6. level mode: re-request after GAP, withdraw on line drop
        cfg_write(3, 1'b1, 1'b1, 3'd3);
        irq_req[3] = 1'b1;
        expect_grant(8'h83, 3'd3);
        wait_grant("t6_lvl", 5);
        ack("t6_a");
        expect_grant(8'h83, 3'd3);
        wait_grant("t6_relvl", 5);
        irq_req[3] = 1'b0;
        tick();
        check("t6_drop", 32'(IRQ), 32'd0);
        tick();
        tick();
        check("t6_idle", 32'(IRQ), 32'd0);
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
